// File: rtl/pio_in_debounce_edge_pkg.sv
// pio_in_debounce_edge_pkg: register map shared by the input PIO files
package pio_in_debounce_edge_pkg;
  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_RAW     = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN = 3'd5;
  localparam logic [2:0] ADDR_DEB     = 3'd6;
endpackage

// File: rtl/pio_debounce_bit.sv
// pio_debounce_bit: one-bit debouncer with a saturating run counter and programmable period
module pio_debounce_bit #(
  parameter int DEB_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sync_in,
  input  logic [DEB_W-1:0] period,
  input  logic             clr_cnt,
  output logic             stable
);
  logic [DEB_W-1:0] cnt;
  logic             done;
  // the run is long enough once cnt+1 reaches the period; periods 0 and 1 are satisfied at once
  always_comb done = ({1'b0, cnt} + (DEB_W+1)'(1)) >= {1'b0, period};
  // counter tracks how long sync has disagreed with stable; stable adopts sync when the run completes
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (clr_cnt || sync_in == stable) begin
      cnt    <= '0;
    end else if (done) begin
      stable <= sync_in;
      cnt    <= '0;
    end else begin
      cnt    <= &cnt ? cnt : cnt + DEB_W'(1);
    end
endmodule

// File: rtl/pio_in_debounce_edge.sv
// pio_in_debounce_edge: Avalon-MM input PIO with per-bit debounce, edge capture and masked irq
module pio_in_debounce_edge
  import pio_in_debounce_edge_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 16,
  parameter int DEB_RST     = 5000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync, stable, prev, mask, capture, rise_en, fall_en, ev, clr;
  logic [DEB_W-1:0] deb;
  logic [31:0]      rd_next;
  logic             wr, clr_cnt, unused_wd;
  // bus decode, edge detection and read mux
  always_comb begin
    wr      = chipselect && !write_n;
    clr_cnt = wr && address == ADDR_DEB;
    sync    = sync_q[SYNC_STAGES-1];
    ev      = (rise_en & stable & ~prev) | (fall_en & ~stable & prev);
    clr     = (wr && address == ADDR_CAPTURE) ? writedata[WIDTH-1:0] : '0;
    rd_next = address == ADDR_DATA    ? 32'(stable)  :
              address == ADDR_RAW     ? 32'(sync)    :
              address == ADDR_MASK    ? 32'(mask)    :
              address == ADDR_CAPTURE ? 32'(capture) :
              address == ADDR_RISE_EN ? 32'(rise_en) :
              address == ADDR_FALL_EN ? 32'(fall_en) :
              address == ADDR_DEB     ? 32'(deb)     : 32'd0;
  end
  assign irq       = |(capture & mask);
  assign unused_wd = ^writedata;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(.DEB_W(DEB_W)) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .sync_in (sync[i]),
      .period  (deb),
      .clr_cnt (clr_cnt),
      .stable  (stable[i])
    );
  end
  // synchroniser chain and previous debounced value for edge detection
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync_q <= '0;
      prev   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev   <= stable;
    end
  // control registers; a new edge wins over a simultaneous write-1-to-clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mask    <= '0;
      capture <= '0;
      rise_en <= '1;
      fall_en <= '0;
      deb     <= DEB_W'(DEB_RST);
    end else begin
      capture <= (capture & ~clr) | ev;
      if (wr && address == ADDR_MASK)    mask    <= writedata[WIDTH-1:0];
      if (wr && address == ADDR_RISE_EN) rise_en <= writedata[WIDTH-1:0];
      if (wr && address == ADDR_FALL_EN) fall_en <= writedata[WIDTH-1:0];
      if (clr_cnt)                       deb     <= writedata[DEB_W-1:0];
    end
  // registered read data, updated every cycle from address
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
endmodule

// File: tb/tb_pio_in_debounce_edge.sv
// tb_pio_in_debounce_edge: directed checks plus randomized run against a cycle-level behavioural model
module tb_pio_in_debounce_edge;
  localparam int W  = 10;
  localparam int SS = 2;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [W-1:0] in_port = '0;
  logic [31:0] readdata;
  logic        irq;
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] hist [SS];
  logic [W-1:0] stab, prv, msk, cap, rise, fall, ev, clr, sync_m;
  int           run [W];
  int           deb;
  logic [31:0]  rd_m;
  logic [31:0]  v;
  logic [31:0]  exp1 [8];

  pio_in_debounce_edge #(.WIDTH(W), .SYNC_STAGES(SS), .DEB_W(16), .DEB_RST(5000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  // model: a bit's debounced value takes the synchronised value once they have disagreed for max(DEB,1) consecutive cycles
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      for (int s = 0; s < SS; s++) hist[s] = '0;
      for (int i = 0; i < W; i++) run[i] = 0;
      stab = '0; prv = '0; msk = '0; cap = '0; rise = '1; fall = '0; deb = 5000; rd_m = '0;
    end else begin
      sync_m = hist[SS-1];
      case (address)
        3'd0: rd_m = 32'(stab);
        3'd1: rd_m = 32'(sync_m);
        3'd2: rd_m = 32'(msk);
        3'd3: rd_m = 32'(cap);
        3'd4: rd_m = 32'(rise);
        3'd5: rd_m = 32'(fall);
        3'd6: rd_m = 32'(deb);
        default: rd_m = '0;
      endcase
      ev  = (rise & stab & ~prv) | (fall & ~stab & prv);
      clr = (chipselect && !write_n && address == 3'd3) ? writedata[W-1:0] : '0;
      cap = (cap & ~clr) | ev;
      prv = stab;
      for (int i = 0; i < W; i++) begin
        if ((chipselect && !write_n && address == 3'd6) || sync_m[i] == stab[i]) run[i] = 0;
        else begin
          run[i]++;
          if (run[i] >= (deb < 1 ? 1 : deb)) begin
            stab[i] = sync_m[i];
            run[i] = 0;
          end
        end
      end
      for (int s = SS - 1; s > 0; s--) hist[s] = hist[s-1];
      hist[0] = in_port;
      if (chipselect && !write_n) begin
        if (address == 3'd2) msk  = writedata[W-1:0];
        if (address == 3'd4) rise = writedata[W-1:0];
        if (address == 3'd5) fall = writedata[W-1:0];
        if (address == 3'd6) deb  = int'(writedata[15:0]);
      end
    end
  end

  // every cycle out of reset, the DUT outputs must equal the model
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      chk("readdata", readdata, rd_m);
      chk("irq", 32'(irq), 32'(|(cap & msk)));
    end
  end

  initial begin
    exp1 = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h3FF, 32'h0, 32'd5000, 32'h0};
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus_rd(3'(a), v);
      chk($sformatf("reset_read_a%0d", a), v, exp1[a]);
    end
    chk("reset_irq", 32'(irq), 32'd0);

    bus_wr(3'd6, 32'd4);
    in_port[0] = 1'b1;
    repeat (3) @(negedge clk);
    in_port[0] = 1'b0;
    repeat (8) @(negedge clk);
    bus_rd(3'd0, v);
    chk("glitch_data", v, 32'h0);
    bus_rd(3'd3, v);
    chk("glitch_capture", v, 32'h0);

    bus_wr(3'd2, 32'h1);
    address = 3'd0;
    in_port[0] = 1'b1;
    repeat (6) @(negedge clk);
    chk("latency_data_before", 32'(readdata[0]), 32'd0);
    chk("latency_irq_before", 32'(irq), 32'd0);
    @(negedge clk);
    chk("latency_data_after", 32'(readdata[0]), 32'd1);
    chk("latency_irq_after", 32'(irq), 32'd1);

    bus_wr(3'd3, 32'h3FF);
    bus_wr(3'd4, 32'h0);
    in_port[9] = 1'b1;
    repeat (10) @(negedge clk);
    bus_wr(3'd5, 32'h200);
    in_port[9] = 1'b0;
    repeat (10) @(negedge clk);
    bus_rd(3'd3, v);
    chk("fall_capture", v, 32'h200);
    chk("fall_irq_masked", 32'(irq), 32'd0);
    bus_wr(3'd2, 32'h201);
    chk("fall_irq_unmasked", 32'(irq), 32'd1);

    bus_wr(3'd3, 32'h3FF);
    bus_wr(3'd4, 32'h3);
    bus_wr(3'd5, 32'h3);
    in_port[1:0] = 2'b10;
    repeat (10) @(negedge clk);
    bus_rd(3'd3, v);
    chk("w1c_setup", v, 32'h003);
    bus_wr(3'd3, 32'h1);
    bus_rd(3'd3, v);
    chk("w1c_clear", v, 32'h002);
    in_port[0] = 1'b1;
    repeat (6) @(negedge clk);
    bus_wr(3'd3, 32'h1);
    bus_rd(3'd3, v);
    chk("w1c_set_priority", v, 32'h003);

    bus_wr(3'd2, 32'h3FF);
    chk("pre_reset_irq", 32'(irq), 32'd1);
    in_port[1] = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_irq", 32'(irq), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bus_rd(3'd6, v);
    chk("post_reset_deb", v, 32'd5000);
    bus_rd(3'd0, v);
    chk("post_reset_data", v, 32'h0);
    bus_rd(3'd3, v);
    chk("post_reset_capture", v, 32'h0);

    bus_wr(3'd6, 32'd3);
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 4) == 0) in_port = in_port ^ W'(1 << $urandom_range(0, W - 1));
      address = 3'($urandom_range(0, 7));
      chipselect = $urandom_range(0, 3) == 0;
      write_n = $urandom_range(0, 1) == 0;
      writedata = (address == 3'd6) ? 32'($urandom_range(0, 6)) : $urandom;
      @(negedge clk);
    end
    chipselect = 1'b0;
    write_n = 1'b1;
    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
